// File: rtl/bcd_convert.sv
// bcd_convert: sequential double-dabble binary-to-BCD converter, one bit per clock,
// with start/busy/done handshake and a captured sign passed through alongside the digits.
module bcd_convert #(
    parameter int W      = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          mag,
    input  logic                  neg,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg_out
);
    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [BW-1:0]   scr_q, scr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            sign_q, sign_d;
    logic            neg_q, neg_d;
    logic [BW-1:0]   adj;
    logic [BW+W-1:0] nxt;

    // Every scratch digit is corrected in parallel before the shift.
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign adj[4*d +: 4] = (scr_q[4*d +: 4] >= 4'd5) ? scr_q[4*d +: 4] + 4'd3 : scr_q[4*d +: 4];
    end

    assign nxt = {adj, shift_q} << 1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = mag;
                    sign_d  = neg;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, shift_d} = nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                    bcd_d   = nxt[W +: BW];
                    neg_d   = sign_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            neg_q   <= neg_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign bcd     = bcd_q;
    assign neg_out = neg_q;
endmodule

// File: tb/tb_bcd_convert.sv
// tb_bcd_convert: randomized self-checking bench for bcd_convert against a
// decimal-arithmetic reference model.
module tb_bcd_convert;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] mag = '0;
    logic        neg = 1'b0;
    logic        busy, done, neg_out;
    logic [15:0] bcd;

    int passed = 0;
    int total  = 0;

    bcd_convert #(.W(13), .DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mag(mag), .neg(neg),
        .busy(busy), .done(done), .bcd(bcd), .neg_out(neg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then measure latency to done and busy width.
    task automatic convert(input logic [12:0] m, input logic n, input string tag);
        int lat = 0;
        int bw = 0;
        mag = m;
        neg = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        mag = 13'($urandom);
        neg = 1'($urandom);
        while (!done && lat < 40) begin
            if (busy) bw++;
            tick();
            lat++;
        end
        if (busy) bw++;
        check({tag, " latency"}, lat, 13);
        check({tag, " bcd"}, {15'd0, neg_out, bcd}, {15'd0, n, to_bcd(int'(m))});
        tick();
        check({tag, " busy width"}, bw, 14);
        check({tag, " done width"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        logic [12:0] mags [0:59];
        logic [15:0] d;
        int seen;
        // Reset held with start asserted must stay idle and cleared.
        start = 1'b1;
        mag = 13'd500;
        repeat (3) tick();
        check("reset outputs", {14'd0, busy, done, neg_out, bcd}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle after reset", {30'd0, busy, done}, 32'd0);

        convert(13'd247, 1'b0, "basic");
        convert(13'd0, 1'b0, "zero");
        convert(13'd8191, 1'b1, "max");
        convert(13'd1999, 1'b0, "1999");
        convert(13'd5, 1'b1, "five");

        // Reset in the middle of a conversion aborts it and clears bcd.
        convert(13'd247, 1'b0, "pre-abort");
        mag = 13'd1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("abort outputs", {14'd0, busy, done, neg_out, bcd}, 32'd0);
        seen = 0;
        repeat (3) begin
            tick();
            seen += int'(done);
        end
        rst_n = 1'b1;
        repeat (14) begin
            tick();
            seen += int'(done);
        end
        check("no done after abort", seen, 0);
        convert(13'd1234, 1'b0, "post-abort");

        // Start held high with mag changing every cycle: each conversion
        // takes the mag present at its own accepting edge.
        start = 1'b1;
        for (int k = 0; k < 60; k++) begin
            mag = 13'($urandom);
            mags[k] = mag;
            tick();
            check($sformatf("held done @%0d", k), {31'd0, done}, {31'd0, (k % 15) == 13});
            if ((k % 15) == 13)
                check($sformatf("held bcd @%0d", k), {16'd0, bcd}, {16'd0, to_bcd(int'(mags[k - 13]))});
        end
        start = 1'b0;
        repeat (16) tick();

        // Random sweep, including the digit range check.
        for (int i = 0; i < 300; i++) begin
            logic [12:0] m;
            m = 13'($urandom);
            convert(m, 1'($urandom), $sformatf("rand %0d", m));
            d = bcd;
            check("digits <= 9", {28'd0, (d[15:12] > 9), (d[11:8] > 9), (d[7:4] > 9), (d[3:0] > 9)}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
